// File: rtl/dbg_pkg.sv
// Shared definitions for the CPU debug/test port responder.
package dbg_pkg;

    localparam int DBG_DATA_W  = 16;
    localparam int DBG_ADDR_W  = 16;
    localparam int DBG_RADDR_W = 4;
    localparam int DBG_SETTLE  = 2;

    localparam logic KIND_MEM = 1'b0;
    localparam logic KIND_REG = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        ACCESS    = 2'd2,
        RESP      = 2'd3
    } dbg_state_t;

endpackage

// File: rtl/dbg_settle_cnt.sv
// Loadable down-counter timing the ACCESS phase; done is high while the count is zero.
module dbg_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/debug_access_ctrl.sv
// Debug-port responder: parks the CPU, performs one memory/register access
// through the test muxes, waits the settle latency and returns the data.
module debug_access_ctrl
    import dbg_pkg::*;
#(
    parameter int DATA_W  = DBG_DATA_W,
    parameter int ADDR_W  = DBG_ADDR_W,
    parameter int RADDR_W = DBG_RADDR_W,
    parameter int SETTLE  = DBG_SETTLE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_kind,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic               cpu_halt,
    input  logic               cpu_idle,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_we,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [RADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               reg_we,
    input  logic [DATA_W-1:0]  reg_rdata
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    dbg_state_t        state_q, state_d;
    logic              lat_kind, lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] sel_rdata;
    logic              cnt_done;
    logic              accept, start, finish;

    assign accept    = (state_q == IDLE) && req_ready && req_valid;
    assign start     = (state_q == HALT_WAIT) && cpu_idle;
    assign finish    = (state_q == ACCESS) && cnt_done;
    assign sel_rdata = (lat_kind == KIND_REG) ? reg_rdata : mem_rdata;

    dbg_settle_cnt #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (CNT_W'(SETTLE - 1)),
        .en       (state_q == ACCESS),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept) state_d = HALT_WAIT;
            HALT_WAIT: if (cpu_idle) state_d = ACCESS;
            ACCESS:    if (cnt_done) state_d = RESP;
            RESP:      if (rsp_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_kind  <= KIND_MEM;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_kind  <= req_kind;
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready <= 1'b0;
            cpu_halt  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
        end else begin
            req_ready <= (state_d == IDLE);
            cpu_halt  <= (state_d != IDLE);
            rsp_valid <= (state_d == RESP);
            mem_we    <= start && lat_write && (lat_kind == KIND_MEM);
            reg_we    <= start && lat_write && (lat_kind == KIND_REG);
            if (start && lat_kind == KIND_MEM) begin
                mem_addr  <= lat_addr;
                mem_wdata <= lat_wdata;
            end
            if (start && lat_kind == KIND_REG) begin
                reg_addr  <= lat_addr[RADDR_W-1:0];
                reg_wdata <= lat_wdata;
            end
            if (finish) begin
                rsp_rdata <= sel_rdata;
                rsp_err   <= lat_write && (sel_rdata != lat_wdata);
            end
        end
    end

endmodule
